serial_parity_sequencer: RTL and testbench

//  Frame controller for the serial group-parity datapath. Collects a serial bit stream into
//  GW-bit groups, computes the XOR parity of each group, and presents {group, parity} on a

---
 rtl/serial_parity_sequencer_if.sv | 29 ++
 rtl/serial_parity_sequencer.sv | 151 +++++++++++++++
 tb/tb_serial_parity_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_parity_sequencer_if.sv
// Handshake bundle between a frame producer/consumer and the serial parity sequencer.
// master drives the request and data side, slave is the sequencer itself.
interface serial_parity_sequencer_if #(
    parameter int GW   = 3,
    parameter int CNTW = 8
) ();
    logic            start;
    logic [CNTW-1:0] n_groups;
    logic            din;
    logic            din_valid;
    logic            din_ready;
    logic [GW-1:0]   grp_out;
    logic            par_out;
    logic            out_valid;
    logic            out_ready;
    logic            grp_strobe;
    logic            busy;
    logic            done;

    modport master (
        output start, n_groups, din, din_valid, out_ready,
        input  din_ready, grp_out, par_out, out_valid, grp_strobe, busy, done
    );

    modport slave (
        input  start, n_groups, din, din_valid, out_ready,
        output din_ready, grp_out, par_out, out_valid, grp_strobe, busy, done
    );
endinterface

// File: rtl/serial_parity_sequencer.sv
// Collects a serial bit stream into GW-bit groups and emits {group, XOR parity} through a
// single-entry valid/ready output register, one frame of n_groups groups per accepted start.
module serial_parity_sequencer #(
    parameter int GW   = 3,
    parameter int CNTW = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    serial_parity_sequencer_if.slave    bus
);
    localparam int BCW = $clog2(GW);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(GW - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CNTW-1:0] r_n_groups;
    logic [CNTW-1:0] r_gcnt;
    logic [BCW-1:0]  r_bit_cnt;
    logic [GW-2:0]   r_shift;
    logic            r_acc;
    logic [GW-1:0]   r_grp_out;
    logic            r_par_out;
    logic            r_out_valid;
    logic            r_grp_strobe;
    logic            r_busy;
    logic            r_done;

    logic            w_din_ready;
    logic            w_bit_acc;
    logic            w_last_bit;
    logic            w_complete;
    logic            w_xfer;
    logic            w_start_acc;
    logic            w_last_grp;
    logic [GW-1:0]   w_shift_nxt;

    // Handshake qualifiers; only the group-completing bit stalls behind a pending output.
    always_comb begin
        w_last_bit  = (r_bit_cnt == LAST_BIT);
        w_xfer      = r_out_valid & bus.out_ready;
        w_din_ready = (r_state == S_RUN) & ~(r_out_valid & ~bus.out_ready & w_last_bit);
        w_bit_acc   = bus.din_valid & w_din_ready;
        w_complete  = w_bit_acc & w_last_bit;
        w_last_grp  = (r_gcnt == (r_n_groups - CNTW'(1)));
        w_start_acc = (r_state == S_IDLE) & bus.start;
        w_shift_nxt = {r_shift, bus.din};
    end

    // Frame sequencing next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.n_groups != {CNTW{1'b0}}) ? S_RUN : S_DONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_complete && w_last_grp) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                if (w_xfer) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register plus registered busy/done decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // Bit collection, group counting and the single-entry output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n_groups   <= {CNTW{1'b0}};
            r_gcnt       <= {CNTW{1'b0}};
            r_bit_cnt    <= {BCW{1'b0}};
            r_shift      <= {(GW-1){1'b0}};
            r_acc        <= 1'b0;
            r_grp_out    <= {GW{1'b0}};
            r_par_out    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_grp_strobe <= 1'b0;
        end else begin
            r_grp_strobe <= w_complete;
            if (w_start_acc) begin
                r_n_groups <= bus.n_groups;
                r_gcnt     <= {CNTW{1'b0}};
                r_bit_cnt  <= {BCW{1'b0}};
                r_shift    <= {(GW-1){1'b0}};
                r_acc      <= 1'b0;
            end else if (w_complete) begin
                r_grp_out <= w_shift_nxt;
                r_par_out <= r_acc ^ bus.din;
                r_shift   <= w_shift_nxt[GW-2:0];
                r_bit_cnt <= {BCW{1'b0}};
                r_acc     <= 1'b0;
                r_gcnt    <= r_gcnt + CNTW'(1);
            end else if (w_bit_acc) begin
                r_shift   <= w_shift_nxt[GW-2:0];
                r_bit_cnt <= r_bit_cnt + BCW'(1);
                r_acc     <= r_acc ^ bus.din;
            end else begin
                r_bit_cnt <= r_bit_cnt;
            end
            // A load on the same edge as a transfer keeps valid high with the new group.
            if (w_complete) begin
                r_out_valid <= 1'b1;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
        end
    end

    assign bus.din_ready  = w_din_ready;
    assign bus.grp_out    = r_grp_out;
    assign bus.par_out    = r_par_out;
    assign bus.out_valid  = r_out_valid;
    assign bus.grp_strobe = r_grp_strobe;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_serial_parity_sequencer.sv
// Directed bench for serial_parity_sequencer (GW=3, CNTW=8) with hand-computed expectations.
module tb_serial_parity_sequencer;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    serial_parity_sequencer_if #(.GW(3), .CNTW(8)) bus ();

    serial_parity_sequencer #(.GW(3), .CNTW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.din       = b;
        bus.din_valid = 1'b1;
        tick();
    endtask

    task automatic idle_in();
        bus.start     = 1'b0;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
    endtask

    logic [11:0] bits2;
    logic [5:0]  bits6;
    logic [2:0]  grp2 [4];
    logic        par2 [4];
    logic        rdy_drop;
    int          s_cnt;
    int          s_c [2];
    int          done_cnt;
    int          bi;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.n_groups  = 8'd0;
        bus.out_ready = 1'b0;
        idle_in();
        #2;
        check("rst_busy",   {31'd0, bus.busy},      32'd0);
        check("rst_valid",  {31'd0, bus.out_valid}, 32'd0);
        check("rst_ready",  {31'd0, bus.din_ready}, 32'd0);
        check("rst_grp",    {29'd0, bus.grp_out},   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: single group 101.
        bus.start = 1'b1; bus.n_groups = 8'd1; bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t1_busy", {31'd0, bus.busy}, 32'd1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        bus.din_valid = 1'b0;
        check("t1_valid",  {31'd0, bus.out_valid},  32'd1);
        check("t1_strobe", {31'd0, bus.grp_strobe}, 32'd1);
        check("t1_grp",    {29'd0, bus.grp_out},    32'd5);
        check("t1_par",    {31'd0, bus.par_out},    32'd0);
        check("t1_drain_rdy", {31'd0, bus.din_ready}, 32'd0);
        tick();
        check("t1_valid_off", {31'd0, bus.out_valid}, 32'd0);
        check("t1_done",      {31'd0, bus.done},      32'd1);
        check("t1_done_busy", {31'd0, bus.busy},      32'd0);
        tick();
        check("t1_done_off", {31'd0, bus.done}, 32'd0);
        check("t1_hold_grp", {29'd0, bus.grp_out}, 32'd5);

        // Test 2: four groups back to back.
        bits2 = 12'b111_001_000_011;
        grp2[0] = 3'd7; grp2[1] = 3'd1; grp2[2] = 3'd0; grp2[3] = 3'd3;
        par2[0] = 1'b1; par2[1] = 1'b1; par2[2] = 1'b0; par2[3] = 1'b0;
        rdy_drop = 1'b0;
        bus.start = 1'b1; bus.n_groups = 8'd4;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.din = bits2[11-i];
            bus.din_valid = 1'b1;
            #1;
            if (!bus.din_ready) rdy_drop = 1'b1;
            tick();
            if (i % 3 == 2) begin
                check("t2_strobe", {31'd0, bus.grp_strobe}, 32'd1);
                check("t2_grp",    {29'd0, bus.grp_out},    {29'd0, grp2[i/3]});
                check("t2_par",    {31'd0, bus.par_out},    {31'd0, par2[i/3]});
            end else begin
                check("t2_nostrobe", {31'd0, bus.grp_strobe}, 32'd0);
            end
        end
        bus.din_valid = 1'b0;
        check("t2_rdy_drop", {31'd0, rdy_drop}, 32'd0);
        tick();
        check("t2_done", {31'd0, bus.done}, 32'd1);
        tick();
        check("t2_done_off", {31'd0, bus.done}, 32'd0);

        // Test 3: backpressure stalls only the completing bit.
        bus.start = 1'b1; bus.n_groups = 8'd2; bus.out_ready = 1'b0;
        tick();
        bus.start = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        check("t3_g1_valid", {31'd0, bus.out_valid}, 32'd1);
        check("t3_g1_grp",   {29'd0, bus.grp_out},   32'd6);
        send_bit(1'b0);
        send_bit(1'b1);
        bus.din = 1'b1; bus.din_valid = 1'b1;
        #1;
        check("t3_stall", {31'd0, bus.din_ready}, 32'd0);
        tick();
        tick();
        check("t3_hold_grp",   {29'd0, bus.grp_out},    32'd6);
        check("t3_hold_rdy",   {31'd0, bus.din_ready},  32'd0);
        check("t3_hold_strb",  {31'd0, bus.grp_strobe}, 32'd0);
        bus.out_ready = 1'b1;
        #1;
        check("t3_release", {31'd0, bus.din_ready}, 32'd1);
        tick();
        bus.din_valid = 1'b0;
        check("t3_g2_valid",  {31'd0, bus.out_valid},  32'd1);
        check("t3_g2_strobe", {31'd0, bus.grp_strobe}, 32'd1);
        check("t3_g2_grp",    {29'd0, bus.grp_out},    32'd3);
        check("t3_g2_par",    {31'd0, bus.par_out},    32'd0);
        tick();
        check("t3_done",      {31'd0, bus.done},      32'd1);
        check("t3_valid_off", {31'd0, bus.out_valid}, 32'd0);
        tick();

        // Test 4: empty frame.
        bus.start = 1'b1; bus.n_groups = 8'd0;
        #1;
        check("t4_ready_idle", {31'd0, bus.din_ready}, 32'd0);
        tick();
        bus.start = 1'b0;
        check("t4_done",  {31'd0, bus.done},      32'd1);
        check("t4_busy",  {31'd0, bus.busy},      32'd0);
        check("t4_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t4_ready", {31'd0, bus.din_ready}, 32'd0);
        tick();
        check("t4_done_off", {31'd0, bus.done}, 32'd0);

        // Test 5: asynchronous reset in the middle of group 2.
        bus.start = 1'b1; bus.n_groups = 8'd2;
        tick();
        bus.start = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        check("t5_pre_busy", {31'd0, bus.busy}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy",  {31'd0, bus.busy},       32'd0);
        check("t5_rst_grp",   {29'd0, bus.grp_out},    32'd0);
        check("t5_rst_ready", {31'd0, bus.din_ready},  32'd0);
        check("t5_rst_valid", {31'd0, bus.out_valid},  32'd0);
        check("t5_rst_done",  {31'd0, bus.done},       32'd0);
        idle_in();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.start = 1'b1; bus.n_groups = 8'd1;
        tick();
        bus.start = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        bus.din_valid = 1'b0;
        check("t5_grp",    {29'd0, bus.grp_out},    32'd6);
        check("t5_par",    {31'd0, bus.par_out},    32'd0);
        check("t5_strobe", {31'd0, bus.grp_strobe}, 32'd1);
        tick();
        tick();

        // Test 6: bits every other cycle, stray start while busy.
        bits6 = 6'b101_111;
        s_cnt = 0; done_cnt = 0; bi = 0;
        s_c[0] = 0; s_c[1] = 0;
        bus.start = 1'b1; bus.n_groups = 8'd2;
        tick();
        for (int c = 0; c < 40; c++) begin
            bus.start = (c == 5);
            bus.n_groups = 8'd5;
            bus.din_valid = 1'b0;
            bus.din = 1'b0;
            if ((c % 2 == 0) && (bi < 6)) begin
                bus.din_valid = 1'b1;
                bus.din = bits6[5-bi];
                bi++;
            end
            tick();
            if (bus.grp_strobe) begin
                if (s_cnt < 2) s_c[s_cnt] = c;
                if (s_cnt == 0) begin
                    check("t6_g1_grp", {29'd0, bus.grp_out}, 32'd5);
                    check("t6_g1_par", {31'd0, bus.par_out}, 32'd0);
                end else begin
                    check("t6_g2_grp", {29'd0, bus.grp_out}, 32'd7);
                    check("t6_g2_par", {31'd0, bus.par_out}, 32'd1);
                end
                s_cnt++;
            end
            if (bus.done) done_cnt++;
        end
        check("t6_strobes", s_cnt, 32'd2);
        check("t6_spacing", s_c[1] - s_c[0], 32'd6);
        check("t6_dones",   done_cnt, 32'd1);
        check("t6_idle",    {31'd0, bus.busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
